// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer
// Schedules conversions on a 12-bit SPI ADC interface core. Periodic or
// one-shot triggers start the start/busy handshake. Each result is captured,
// and optionally boxcar-averaged over 2^AVG_LOG2 samples. A timeout guards
// against a core that never answers.
module adc_sample_sequencer #(
  parameter int PERIOD   = 10000,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 4096,
  parameter int SYNC     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        oneshot,
  output logic        adc_start,
  input  logic        adc_busy,
  input  logic        adc_new_data,
  input  logic [11:0] adc_data,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic [11:0] avg,
  output logic        avg_valid,
  output logic        overrun,
  output logic        timeout_err,
  output logic        active
);

  localparam int PCNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int TCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int ACC_W  = 12 + AVG_LOG2;
  // A zero-width sample counter is not legal, so n keeps at least one bit.
  // The wrap is detected against N_LAST instead of by natural overflow.
  localparam int N_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [N_W-1:0] N_LAST = N_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CONV,
    S_ACCUM,
    S_DRAIN
  } state_t;

  state_t              state, state_next;
  logic [SYNC-1:0]     busy_sync, nd_sync;
  logic                busy_s, nd_s, nd_s_d1, nd_rise;
  logic [PCNT_W-1:0]   pcnt;
  logic [TCNT_W-1:0]   tcnt;
  logic                tick, trigger, tmo;
  logic                start_next, capture, abort;
  logic                acc_en, enable_d1, acc_clear;
  logic [ACC_W-1:0]    acc, acc_base, acc_sum;
  logic [N_W-1:0]      n, n_base;

  assign busy_s  = busy_sync[SYNC-1];
  assign nd_s    = nd_sync[SYNC-1];
  assign nd_rise = nd_s & ~nd_s_d1;
  assign tick    = enable && (pcnt == PCNT_W'(PERIOD - 1));
  assign trigger = tick | oneshot;
  assign tmo     = (tcnt == TCNT_W'(TIMEOUT - 1));
  assign active  = (state != S_IDLE);

  // Bring the slow-domain busy/new_data levels into clk before any decision uses them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_sync <= '0;
      nd_sync   <= '0;
      nd_s_d1   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      busy_sync <= {busy_sync[SYNC-2:0], adc_busy};
      nd_sync   <= {nd_sync[SYNC-2:0], adc_new_data};
      nd_s_d1   <= nd_s;
    end
  end

  // Free-running period counter; parked at zero while triggering is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               pcnt <= '0;
    else if (!enable)                      pcnt <= '0;
    else if (pcnt == PCNT_W'(PERIOD - 1))  pcnt <= '0;
    else                                   pcnt <= pcnt + PCNT_W'(1);
  end

  // Timeout counter: zeroed in IDLE, frozen in ACCUM and at its terminal value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             tcnt <= '0;
    else if (state == S_IDLE)            tcnt <= '0;
    else if (state != S_ACCUM && !tmo)   tcnt <= tcnt + TCNT_W'(1);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic with the capture/abort strobes it implies.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    capture    = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE:  if (trigger) state_next = S_REQ;
      S_REQ: begin
        if (tmo) begin
          abort      = 1'b1;
          state_next = S_IDLE;
        end else if (busy_s) begin
          state_next = S_CONV;
        end
      end
      S_CONV: begin
        if (tmo) begin
          abort      = 1'b1;
          state_next = S_IDLE;
        end else if (nd_rise) begin
          capture    = 1'b1;
          state_next = S_ACCUM;
        end
      end
      S_ACCUM: state_next = S_DRAIN;
      S_DRAIN: begin
        // The sample is already delivered, so a core that has gone idle
        // completes normally even if the timeout hits in the same cycle.
        if (!busy_s) begin
          state_next = S_IDLE;
        end else if (tmo) begin
          abort      = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // The core samples start on its slow clock, so start is held for the whole of REQ.
    start_next = (state_next == S_REQ);
  end

  // When enable falls, a partial average is discarded. An add landing
  // in that same cycle starts from an empty accumulator.
  assign acc_clear = enable_d1 & ~enable;
  assign acc_base  = acc_clear ? '0 : acc;
  assign n_base    = acc_clear ? '0 : n;
  assign acc_sum   = acc_base + ACC_W'(sample);

  // Registered outputs, result capture and boxcar accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_start    <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      avg          <= '0;
      avg_valid    <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
      acc_en       <= 1'b0;
      enable_d1    <= 1'b0;
      acc          <= '0;
      n            <= '0;
    end else begin
      adc_start    <= start_next;
      sample_valid <= capture;
      timeout_err  <= abort;
      overrun      <= tick && (state != S_IDLE);
      avg_valid    <= 1'b0;
      enable_d1    <= enable;
      if (capture) sample <= adc_data;
      if (state == S_IDLE && trigger) acc_en <= enable;
      if (state == S_ACCUM && acc_en) begin
        if (n_base == N_LAST) begin
          avg       <= acc_sum[ACC_W-1:AVG_LOG2];
          avg_valid <= 1'b1;
          acc       <= '0;
          n         <= '0;
        end else begin
          acc <= acc_sum;
          n   <= n_base + N_W'(1);
        end
      end else if (acc_clear) begin
        acc <= '0;
        n   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb_adc_sample_sequencer
// Directed bench for adc_sample_sequencer with a behavioural ADC core model.
module tb_adc_sample_sequencer;

  localparam int PERIOD   = 200;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 300;
  localparam int SYNC     = 2;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        oneshot;
  logic        adc_start;
  logic        adc_busy;
  logic        adc_new_data;
  logic [11:0] adc_data;
  logic [11:0] sample;
  logic        sample_valid;
  logic [11:0] avg;
  logic        avg_valid;
  logic        overrun;
  logic        timeout_err;
  logic        active;

  adc_sample_sequencer #(
    .PERIOD   (PERIOD),
    .AVG_LOG2 (AVG_LOG2),
    .TIMEOUT  (TIMEOUT),
    .SYNC     (SYNC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .oneshot      (oneshot),
    .adc_start    (adc_start),
    .adc_busy     (adc_busy),
    .adc_new_data (adc_new_data),
    .adc_data     (adc_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .avg          (avg),
    .avg_valid    (avg_valid),
    .overrun      (overrun),
    .timeout_err  (timeout_err),
    .active       (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle counter and output monitors, sampled on the falling edge.
  int          cyc = 0;
  int          n_sv = 0, n_av = 0, n_ovr = 0, n_to = 0, n_rise = 0;
  int          rise_cyc = 0, fall_cyc = 0, av_cyc = 0;
  int          sv_t [64];
  logic [11:0] sv_val [64];
  logic        start_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    start_d <= adc_start;
    if (adc_start && !start_d) begin
      n_rise   <= n_rise + 1;
      rise_cyc <= cyc;
    end
    if (!adc_start && start_d) fall_cyc <= cyc;
    if (sample_valid) begin
      if (n_sv < 64) begin
        sv_t[n_sv]   <= cyc;
        sv_val[n_sv] <= sample;
      end
      n_sv <= n_sv + 1;
    end
    if (avg_valid) begin
      n_av   <= n_av + 1;
      av_cyc <= cyc;
    end
    if (overrun)     n_ovr <= n_ovr + 1;
    if (timeout_err) n_to  <= n_to + 1;
  end

  // Behavioural ADC core: busy after bfm_busy_dly cycles, result after bfm_conv.
  int          bfm_busy_dly = 3;
  int          bfm_conv     = 20;
  logic        bfm_off      = 1'b0;
  int          nd_cyc       = 0;
  logic [11:0] bfm_q [$];

  initial begin
    adc_busy     = 1'b0;
    adc_new_data = 1'b0;
    adc_data     = 12'h000;
    forever begin
      @(negedge clk);
      if (adc_start && !bfm_off) begin
        repeat (bfm_busy_dly) @(negedge clk);
        adc_busy = 1'b1;
        repeat (bfm_conv - bfm_busy_dly) @(negedge clk);
        adc_data     = (bfm_q.size() > 0) ? bfm_q.pop_front() : 12'h000;
        adc_new_data = 1'b1;
        adc_busy     = 1'b0;
        nd_cyc       = cyc;
        repeat (4) @(negedge clk);
        adc_new_data = 1'b0;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_sv(input int target, input int budget, input string tag);
    int k = 0;
    while (n_sv < target && k < budget) begin
      step();
      k++;
    end
    check(tag, n_sv, target);
  endtask

  task automatic wait_rise(input int target, input int budget, input string tag);
    int k = 0;
    while (n_rise < target && k < budget) begin
      step();
      k++;
    end
    check(tag, n_rise, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int b_sv, b_av, b_ovr, b_to, b_rise, r0, k;

  initial begin
    rst     = 1'b1;
    enable  = 1'b0;
    oneshot = 1'b0;

    // Reset state.
    #12;
    check("rst_adc_start",    adc_start,    0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_avg_valid",    avg_valid,    0);
    check("rst_sample",       sample,       0);
    check("rst_avg",          avg,          0);
    check("rst_overrun",      overrun,      0);
    check("rst_timeout_err",  timeout_err,  0);
    check("rst_active",       active,       0);
    step();
    rst = 1'b0;
    step(3);

    // Reset in the middle of a conversion.
    bfm_q.push_back(12'h555);
    oneshot = 1'b1;
    step();
    oneshot = 1'b0;
    step(9);
    check("mid_conv_active", active, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_start",  adc_start, 0);
    check("async_rst_active", active,    0);
    step(2);
    rst  = 1'b0;
    b_sv = n_sv;
    b_av = n_av;
    step(60);
    check("post_rst_no_sv",  n_sv - b_sv, 0);
    check("post_rst_no_av",  n_av - b_av, 0);
    check("post_rst_sample", sample,      0);

    // One-shot with averaging disabled.
    bfm_q.push_back(12'hABC);
    b_sv = n_sv;
    b_av = n_av;
    oneshot = 1'b1;
    step();
    oneshot = 1'b0;
    wait_sv(b_sv + 1, 100, "oneshot_sv");
    check("oneshot_sample",  sample, 12'hABC);
    check("oneshot_latency", sv_t[b_sv] - nd_cyc, SYNC + 1);
    step(5);
    check("oneshot_no_av",   n_av - b_av, 0);
    check("oneshot_idle",    active, 0);

    // Periodic conversions averaged over four samples.
    for (int i = 0; i < 4; i++) bfm_q.push_back(12'h100 + 12'(i));
    b_sv = n_sv;
    b_av = n_av;
    enable = 1'b1;
    wait_sv(b_sv + 4, 1000, "periodic_sv4");
    step(3);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) check($sformatf("periodic_val%0d", i), sv_val[b_sv + i], 12'h100 + i);
    for (int i = 1; i < 4; i++) check($sformatf("periodic_gap%0d", i), sv_t[b_sv + i] - sv_t[b_sv + i - 1], PERIOD);
    check("avg_count",   n_av - b_av, 1);
    check("avg_value",   avg, 12'h101);
    check("avg_latency", av_cyc - sv_t[b_sv + 3], 1);
    step(5);

    // Tick and one-shot in the same cycle.
    bfm_q.push_back(12'h010);
    b_sv   = n_sv;
    b_ovr  = n_ovr;
    b_rise = n_rise;
    enable = 1'b1;
    repeat (PERIOD - 1) @(posedge clk);
    @(negedge clk);
    #1 oneshot = 1'b1;
    step();
    oneshot = 1'b0;
    step(100);
    enable = 1'b0;
    check("coincide_starts",  n_rise - b_rise, 1);
    check("coincide_sv",      n_sv - b_sv,     1);
    check("coincide_no_ovr",  n_ovr - b_ovr,   0);
    check("coincide_sample",  sample,          12'h010);
    step(5);

    // Slow core: each conversion spans one tick, which is dropped.
    bfm_conv = 250;
    for (int i = 0; i < 3; i++) bfm_q.push_back(12'h201 + 12'(i));
    b_sv  = n_sv;
    b_ovr = n_ovr;
    enable = 1'b1;
    wait_sv(b_sv + 3, 1500, "slow_sv3");
    enable = 1'b0;
    check("slow_overruns", n_ovr - b_ovr, 3);
    for (int i = 0; i < 3; i++) check($sformatf("slow_val%0d", i), sv_val[b_sv + i], 12'h201 + i);
    step(30);
    bfm_conv = 20;

    // Core that never acknowledges: timeout, then retry on the next tick.
    bfm_off = 1'b1;
    b_sv   = n_sv;
    b_to   = n_to;
    b_ovr  = n_ovr;
    b_rise = n_rise;
    enable = 1'b1;
    wait_rise(b_rise + 1, PERIOD + 60, "timeout_first_start");
    r0 = rise_cyc;
    k  = 0;
    while (adc_start && k < TIMEOUT + 50) begin
      step();
      k++;
    end
    check("timeout_start_dropped", adc_start, 0);
    check("timeout_start_len",     fall_cyc - r0, TIMEOUT);
    step(2);
    check("timeout_err_count",     n_to - b_to,   1);
    check("timeout_overrun",       n_ovr - b_ovr, 1);
    check("timeout_idle",          active,        0);
    check("timeout_no_sv",         n_sv - b_sv,   0);
    wait_rise(b_rise + 2, PERIOD, "timeout_retry_start");
    check("timeout_retry_spacing", rise_cyc - r0, 2 * PERIOD);
    enable = 1'b0;
    bfm_q.push_back(12'h7E5);
    bfm_off = 1'b0;
    wait_sv(b_sv + 1, 100, "retry_sv");
    check("retry_sample",   sample,      12'h7E5);
    check("retry_no_extra_timeout", n_to - b_to, 1);
    step(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
